// File: rtl/memshare_grantsched.sv
// memshare_grantsched: snapshots share-request flags and grants requestors one at a time in ascending index order
module memshare_grantsched #(
  parameter int SHARED_BANK_NUM    = 5,
  parameter int RQST_ADDR_BITWIDTH = 3,
  parameter int IDX_BITWIDTH       = 3
) (
  input  logic                                         sys_clk,
  input  logic                                         rstn,
  input  logic                                         rqst_valid_i,
  input  logic [SHARED_BANK_NUM-1:0]                   share_rqstFlag_i,
  input  logic [RQST_ADDR_BITWIDTH*SHARED_BANK_NUM-1:0] rqst_addr_i,
  output logic                                         rqst_ready_o,
  output logic                                         busy_o,
  output logic                                         grant_valid_o,
  input  logic                                         grant_ready_i,
  output logic [IDX_BITWIDTH-1:0]                      grant_idx_o,
  output logic [SHARED_BANK_NUM-1:0]                   grant_onehot_o,
  output logic [RQST_ADDR_BITWIDTH-1:0]                grant_addr_o,
  output logic                                         endFlag_o
);
  localparam int N = SHARED_BANK_NUM;
  localparam int W = RQST_ADDR_BITWIDTH;
  typedef enum logic {IDLE, SERVE} state_t;
  state_t                  r_state, w_state_nxt;
  logic [N-1:0]            r_pending, w_pending_nxt, w_src, w_oh, r_oh, w_oh_nxt;
  logic [N*W-1:0]          r_addr, w_addr_nxt, w_src_addr;
  logic                    r_valid, w_valid_nxt, r_end, w_end_nxt, w_load;
  logic [IDX_BITWIDTH-1:0] r_idx, w_idx_nxt, w_idx;
  logic [W-1:0]            r_gaddr, w_gaddr_nxt, w_lane;
  assign rqst_ready_o   = (r_state == IDLE);
  assign busy_o         = (r_state == SERVE);
  assign grant_valid_o  = r_valid;
  assign grant_idx_o    = r_idx;
  assign grant_onehot_o = r_oh;
  assign grant_addr_o   = r_gaddr;
  assign endFlag_o      = r_end;
  // Lowest set bit of the fresh flags (IDLE) or of the remaining pending set (SERVE)
  always_comb begin
    w_src      = (r_state == IDLE) ? share_rqstFlag_i : r_pending;
    w_src_addr = (r_state == IDLE) ? rqst_addr_i : r_addr;
    w_idx      = '0;
    w_oh       = '0;
    w_lane     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_src[i]) begin
        w_idx  = IDX_BITWIDTH'(i);
        w_oh   = N'(1) << i;
        w_lane = w_src_addr[i*W +: W];
      end
    end
  end
  // Next-state and next grant register values
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_addr_nxt    = r_addr;
    w_valid_nxt   = r_valid;
    w_idx_nxt     = r_idx;
    w_oh_nxt      = r_oh;
    w_gaddr_nxt   = r_gaddr;
    w_end_nxt     = 1'b0;
    w_load        = 1'b0;
    if (r_state == IDLE) begin
      if (rqst_valid_i) begin
        w_load      = |share_rqstFlag_i;
        w_end_nxt   = ~|share_rqstFlag_i;
        w_addr_nxt  = w_load ? rqst_addr_i : r_addr;
        w_state_nxt = w_load ? SERVE : IDLE;
      end
    end else if (r_valid && grant_ready_i) begin
      if (|r_pending) begin
        w_load = 1'b1;
      end else begin
        w_valid_nxt = 1'b0;
        w_idx_nxt   = '0;
        w_oh_nxt    = '0;
        w_gaddr_nxt = '0;
        w_end_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end
    end
    if (w_load) begin
      w_valid_nxt   = 1'b1;
      w_idx_nxt     = w_idx;
      w_oh_nxt      = w_oh;
      w_gaddr_nxt   = w_lane;
      w_pending_nxt = w_src & ~w_oh;
    end
  end
  // State and grant registers, cleared asynchronously so an in-flight snapshot is dropped
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_addr    <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_oh      <= '0;
      r_gaddr   <= '0;
      r_end     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_addr    <= w_addr_nxt;
      r_valid   <= w_valid_nxt;
      r_idx     <= w_idx_nxt;
      r_oh      <= w_oh_nxt;
      r_gaddr   <= w_gaddr_nxt;
      r_end     <= w_end_nxt;
    end
  end
endmodule
